// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory access arbiter.
package mem_arb_pkg;

  localparam int unsigned MAX_RD_LATENCY = 4;
  localparam int unsigned PERF_CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_WR = 2'd1,
    ISSUE_RD = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_t;

endpackage

// File: rtl/rd_valid_pipe.sv
// Shift register of read-valid bits tracking reads in flight through the RAM.
// load_c is high in the cycle before valid_out rises, so the parent can
// capture read data on the same edge that raises valid_out.
module rd_valid_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_in,
  output logic valid_out,
  output logic load_c,
  output logic pending_c
);

  logic [DEPTH-1:0] stages;
  logic [DEPTH-1:0] stages_nxt;

  // Next contents: shift toward the output, new issue enters at bit 0.
  always_comb begin
    stages_nxt = (stages << 1) | DEPTH'(valid_in);
  end

  assign load_c    = stages_nxt[DEPTH-1];
  assign pending_c = |stages_nxt;
  assign valid_out = stages[DEPTH-1];

  // Valid pipeline register; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= stages_nxt;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between a write channel and
// a read channel, one RAM operation per cycle. Read data is captured on the
// RD_LATENCY-th clock edge after the cycle in which mem_read_enable is high.
// Optional build macro MEM_ARB_PERF_CNT_EN adds saturating wr/rd ack counters.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic                  rd_ack,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W-1:0]     mem_write_data,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  input  logic [DATA_W-1:0]     mem_read_data,
  output logic                  busy
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] wr_count,
  output logic [PERF_CNT_W-1:0] rd_count
`endif
);

  // Out-of-range latencies are clamped into the supported 1..MAX range.
  localparam int unsigned PIPE_DEPTH =
    (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY :
    (RD_LATENCY < 1)              ? 1              : RD_LATENCY;

  arb_state_t        state, state_nxt;
  grant_t            last_grant, last_grant_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic [DATA_W-1:0] rd_data_nxt;
  logic              we_nxt, re_nxt, busy_nxt;
  logic              rd_load_c, rd_pending_c;

  rd_valid_pipe #(
    .DEPTH(PIPE_DEPTH)
  ) u_rd_valid_pipe (
    .clk      (clock),
    .rst_n    (reset),
    .valid_in (mem_read_enable),
    .valid_out(rd_valid),
    .load_c   (rd_load_c),
    .pending_c(rd_pending_c)
  );

  // Next-state decision and next values of every registered output.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    addr_nxt       = mem_address;
    wdata_nxt      = mem_write_data;
    we_nxt         = 1'b0;
    re_nxt         = 1'b0;

    case (state)
      IDLE: begin
        if (wr_req && rd_req) begin
          state_nxt = (last_grant == GRANT_RD) ? ISSUE_WR : ISSUE_RD;
        end else if (wr_req) begin
          state_nxt = ISSUE_WR;
        end else if (rd_req) begin
          state_nxt = ISSUE_RD;
        end
      end
      // The acked requester is about to drop its req, so only the other side counts.
      ISSUE_WR: state_nxt = rd_req ? ISSUE_RD : IDLE;
      ISSUE_RD: state_nxt = wr_req ? ISSUE_WR : IDLE;
      default:  state_nxt = IDLE;
    endcase

    case (state_nxt)
      ISSUE_WR: begin
        last_grant_nxt = GRANT_WR;
        addr_nxt       = wr_addr;
        wdata_nxt      = wr_data;
        we_nxt         = 1'b1;
      end
      ISSUE_RD: begin
        last_grant_nxt = GRANT_RD;
        addr_nxt       = rd_addr;
        re_nxt         = 1'b1;
      end
      default: ;
    endcase

    busy_nxt    = (state_nxt != IDLE) || rd_pending_c;
    rd_data_nxt = rd_load_c ? mem_read_data : rd_data;
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      last_grant       <= GRANT_RD;
      mem_address      <= '0;
      mem_write_data   <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      wr_ack           <= 1'b0;
      rd_ack           <= 1'b0;
      busy             <= 1'b0;
      rd_data          <= '0;
    end else begin
      state            <= state_nxt;
      last_grant       <= last_grant_nxt;
      mem_address      <= addr_nxt;
      mem_write_data   <= wdata_nxt;
      mem_write_enable <= we_nxt;
      mem_read_enable  <= re_nxt;
      wr_ack           <= we_nxt;
      rd_ack           <= re_nxt;
      busy             <= busy_nxt;
      rd_data          <= rd_data_nxt;
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  // Saturating counters of issued writes and reads.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (wr_ack && (wr_count != '1)) wr_count <= wr_count + PERF_CNT_W'(1);
      if (rd_ack && (rd_count != '1)) rd_count <= rd_count + PERF_CNT_W'(1);
    end
  end
`endif

endmodule
